// File: rtl/shift_frame_rx_pkg.sv
// Shared definitions for the serial frame receive/transmit pair:
// FSM state encoding and the framing bit levels.
package shift_frame_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

endpackage

// File: rtl/shift_frame_rx_rx_shift_core.sv
// Deserializing shift register with selectable fill direction and a running
// XOR of every data bit shifted in since the last clear.
module rx_shift_core #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             clear,
  input  logic             shift,
  input  logic             bit_in,
  output logic [WIDTH-1:0] word,
  output logic             parity
);

  logic [WIDTH-1:0] shifted;

  // LSB-first fills from the top so the first bit lands in bit 0;
  // MSB-first fills from the bottom so the first bit lands in the top bit.
  generate
    if (WIDTH == 1) begin : g_single
      assign shifted = bit_in;
    end else if (MSB_FIRST) begin : g_msb
      assign shifted = {word[WIDTH-2:0], bit_in};
    end else begin : g_lsb
      assign shifted = {bit_in, word[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!clr || clear) begin
      word   <= '0;
      parity <= 1'b0;
    end else if (shift) begin
      word   <= shifted;
      parity <= parity ^ bit_in;
    end
  end

endmodule

// File: rtl/shift_frame_rx.sv
// Serial frame receiver: start bit, WIDTH data bits, even parity, stop bit.
// Completed good words are offered on a valid/ack handshake with overrun flag.
import shift_frame_rx_pkg::*;

module shift_frame_rx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             sen,
  input  logic             sdata,
  input  logic             ack,
  output logic [WIDTH-1:0] Q,
  output logic             valid,
  output logic             perr,
  output logic             ferr,
  output logic             ovr
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  rx_state_t        state, state_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic             par_bad, par_bad_next;
  logic             perr_next, ferr_next;
  logic             core_clear, core_shift, load;
  logic [WIDTH-1:0] word;
  logic             data_parity;

  rx_shift_core #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_core (
    .clk   (clk),
    .clr   (clr),
    .clear (core_clear),
    .shift (core_shift),
    .bit_in(sdata),
    .word  (word),
    .parity(data_parity)
  );

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    par_bad_next = par_bad;
    perr_next    = 1'b0;
    ferr_next    = 1'b0;
    core_clear   = 1'b0;
    core_shift   = 1'b0;
    load         = 1'b0;
    case (state)
      IDLE: begin
        if (sen && sdata == START_BIT) begin
          state_next = DATA;
          cnt_next   = '0;
          core_clear = 1'b1;
        end
      end
      DATA: begin
        if (sen) begin
          core_shift = 1'b1;
          cnt_next   = cnt + CW'(1);
          if (cnt == LAST) state_next = PARITY;
        end
      end
      PARITY: begin
        if (sen) begin
          par_bad_next = data_parity ^ sdata;
          state_next   = STOP;
        end
      end
      STOP: begin
        // A bad stop bit masks any parity error on the same frame.
        if (sen) begin
          state_next = IDLE;
          if (sdata != STOP_BIT) ferr_next = 1'b1;
          else if (par_bad)      perr_next = 1'b1;
          else                   load      = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state   <= IDLE;
      cnt     <= '0;
      par_bad <= 1'b0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
      Q       <= '0;
      valid   <= 1'b0;
      ovr     <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      par_bad <= par_bad_next;
      perr    <= perr_next;
      ferr    <= ferr_next;
      // A new word wins over ack; overrun only if the old word was never taken.
      if (load) begin
        Q     <= word;
        valid <= 1'b1;
        if (valid && !ack) ovr <= 1'b1;
      end else if (ack) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_shift_frame_rx.sv
// Self-checking bench: an LSB-first and an MSB-first receiver share one input
// stream and are compared every cycle against a bit-queue frame model.
module tb_shift_frame_rx;

  localparam int W = 4;

  logic clk = 1'b0;
  logic clr = 1'b0, sen = 1'b0, sdata = 1'b0, ack = 1'b0;
  logic [W-1:0] q_lsb, q_msb;
  logic valid_lsb, perr_lsb, ferr_lsb, ovr_lsb;
  logic valid_msb, perr_msb, ferr_msb, ovr_msb;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Model state: frame bits after the start bit are queued until complete.
  logic       m_in_frame = 1'b0;
  logic       m_bits[$];
  logic [W-1:0] m_q_lsb = '0, m_q_msb = '0;
  logic       m_valid = 1'b0, m_perr = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0;

  typedef struct {
    logic [6:0]   frame;
    int           gap;
    logic [W-1:0] q_lsb;
    logic [W-1:0] q_msb;
    logic         valid;
    logic         perr;
    logic         ferr;
  } vec_t;

  vec_t vecs[7];

  shift_frame_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .clr(clr), .sen(sen), .sdata(sdata), .ack(ack),
    .Q(q_lsb), .valid(valid_lsb), .perr(perr_lsb), .ferr(ferr_lsb), .ovr(ovr_lsb)
  );

  shift_frame_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .clr(clr), .sen(sen), .sdata(sdata), .ack(ack),
    .Q(q_msb), .valid(valid_msb), .perr(perr_msb), .ferr(ferr_msb), .ovr(ovr_msb)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_edge(input logic c, input logic s, input logic d, input logic a);
    int ones;
    logic [W-1:0] wl, wm;
    logic loaded;
    if (!c) begin
      m_in_frame = 1'b0;
      m_bits.delete();
      m_q_lsb = '0; m_q_msb = '0;
      m_valid = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
      return;
    end
    m_perr = 1'b0;
    m_ferr = 1'b0;
    loaded = 1'b0;
    if (s) begin
      if (!m_in_frame) begin
        if (d) begin
          m_in_frame = 1'b1;
          m_bits.delete();
        end
      end else begin
        m_bits.push_back(d);
        if (m_bits.size() == W + 2) begin
          m_in_frame = 1'b0;
          ones = 0;
          for (int i = 0; i <= W; i++) ones += int'(m_bits[i]);
          if (m_bits[W + 1]) m_ferr = 1'b1;
          else if (ones % 2 != 0) m_perr = 1'b1;
          else begin
            wl = '0; wm = '0;
            for (int i = 0; i < W; i++) begin
              wl[i]         = m_bits[i];
              wm[W - 1 - i] = m_bits[i];
            end
            if (m_valid && !a) m_ovr = 1'b1;
            m_q_lsb = wl;
            m_q_msb = wm;
            m_valid = 1'b1;
            loaded  = 1'b1;
          end
        end
      end
    end
    if (!loaded && a) m_valid = 1'b0;
  endtask

  task automatic check_output();
    check_value("q_lsb",     16'(q_lsb),     16'(m_q_lsb));
    check_value("q_msb",     16'(q_msb),     16'(m_q_msb));
    check_value("valid_lsb", 16'(valid_lsb), 16'(m_valid));
    check_value("valid_msb", 16'(valid_msb), 16'(m_valid));
    check_value("perr_lsb",  16'(perr_lsb),  16'(m_perr));
    check_value("perr_msb",  16'(perr_msb),  16'(m_perr));
    check_value("ferr_lsb",  16'(ferr_lsb),  16'(m_ferr));
    check_value("ferr_msb",  16'(ferr_msb),  16'(m_ferr));
    check_value("ovr_lsb",   16'(ovr_lsb),   16'(m_ovr));
    check_value("ovr_msb",   16'(ovr_msb),   16'(m_ovr));
  endtask

  // Drive one clock edge's worth of inputs, advance the model, then sample.
  task automatic apply_stimulus(input logic c, input logic s, input logic d, input logic a);
    clr = c; sen = s; sdata = d; ack = a;
    @(posedge clk);
    model_edge(c, s, d, a);
    #1;
    check_output();
  endtask

  // Frame bits are sent from bit 6 down to bit 0, so literals read in send order.
  task automatic send_frame(input logic [6:0] f, input int gap, input logic ack_last);
    for (int i = 6; i >= 0; i--) begin
      apply_stimulus(1'b1, 1'b1, f[i], (i == 0) ? ack_last : 1'b0);
      if (i > 0) repeat (gap) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic do_reset();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [W-1:0] data;
    logic [6:0]   f;
    logic         pbit, sbit;
    int           gap, cut;

    vecs[0] = '{7'b1001100, 0, 4'b1100, 4'b0011, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{7'b1001100, 3, 4'b1100, 4'b0011, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{7'b1100000, 0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{7'b1001101, 0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{7'b1010100, 1, 4'b1010, 4'b0101, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{7'b1100010, 0, 4'b0001, 4'b1000, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{7'b1111100, 2, 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0};

    do_reset();
    do_reset();
    check_value("reset_q",     16'(q_lsb),     16'h0);
    check_value("reset_valid", 16'(valid_lsb), 16'h0);
    check_value("reset_ovr",   16'(ovr_msb),   16'h0);

    for (int v = 0; v < 7; v++) begin
      do_reset();
      send_frame(vecs[v].frame, vecs[v].gap, 1'b0);
      check_value($sformatf("vec%0d_q_lsb", v), 16'(q_lsb),     16'(vecs[v].q_lsb));
      check_value($sformatf("vec%0d_q_msb", v), 16'(q_msb),     16'(vecs[v].q_msb));
      check_value($sformatf("vec%0d_valid", v), 16'(valid_lsb), 16'(vecs[v].valid));
      check_value($sformatf("vec%0d_perr", v),  16'(perr_lsb),  16'(vecs[v].perr));
      check_value($sformatf("vec%0d_ferr", v),  16'(ferr_msb),  16'(vecs[v].ferr));
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1);
      check_value($sformatf("vec%0d_ack_valid", v), 16'(valid_lsb), 16'h0);
      check_value($sformatf("vec%0d_pulse_end", v), 16'({perr_lsb, ferr_lsb}), 16'h0);
    end

    // Reset in the middle of a frame, then a clean frame.
    do_reset();
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0);
    do_reset();
    check_value("midreset_q",     16'(q_lsb),     16'h0);
    check_value("midreset_valid", 16'(valid_lsb), 16'h0);
    send_frame(7'b1001100, 0, 1'b0);
    check_value("postreset_q", 16'(q_lsb), 16'hC);

    // Stop error followed directly by a good frame.
    do_reset();
    send_frame(7'b1001101, 0, 1'b0);
    check_value("stoperr_ferr", 16'(ferr_lsb), 16'h1);
    send_frame(7'b1010100, 0, 1'b0);
    check_value("after_ferr_q",     16'(q_lsb),     16'hA);
    check_value("after_ferr_valid", 16'(valid_msb), 16'h1);

    // Overrun: two words, no ack.
    do_reset();
    send_frame(7'b1001100, 0, 1'b0);
    send_frame(7'b1010100, 0, 1'b0);
    check_value("ovr_q",     16'(q_lsb),     16'hA);
    check_value("ovr_valid", 16'(valid_lsb), 16'h1);
    check_value("ovr_flag",  16'(ovr_lsb),   16'h1);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1);
    check_value("ovr_sticky", 16'(ovr_lsb), 16'h1);

    // Ack on the same edge as the second word's stop bit: no overrun.
    do_reset();
    send_frame(7'b1001100, 0, 1'b0);
    send_frame(7'b1010100, 0, 1'b1);
    check_value("simack_q",     16'(q_lsb),     16'hA);
    check_value("simack_valid", 16'(valid_lsb), 16'h1);
    check_value("simack_ovr",   16'(ovr_lsb),   16'h0);

    // Randomized frames with gaps, idle noise, random ack and occasional resets.
    do_reset();
    for (int n = 0; n < 300; n++) begin
      data = W'($urandom);
      pbit = ^data;
      if ($urandom_range(0, 4) == 0) pbit = ~pbit;
      sbit = ($urandom_range(0, 7) == 0);
      f    = {1'b1, data[0], data[1], data[2], data[3], pbit, sbit};
      gap  = $urandom_range(0, 2);
      cut  = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 6) : -1;
      for (int i = 6; i >= 0; i--) begin
        if (6 - i == cut) begin
          do_reset();
          break;
        end
        apply_stimulus(1'b1, 1'b1, f[i], 1'($urandom_range(0, 3) == 0));
        for (int g = 0; g < gap; g++)
          apply_stimulus(1'b1, 1'b0, 1'($urandom), 1'($urandom_range(0, 3) == 0));
      end
      repeat ($urandom_range(0, 2))
        apply_stimulus(1'b1, 1'($urandom), 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
